// File: rtl/dm_ctrl_pkg.sv
// Shared encodings for the data-memory access controller.
//   - cpu_op encodings for loads and stores
//   - FSM state encoding
//   - exception codes reported on exc_code
//   - access-size decode helper
package dm_ctrl_pkg;

    // Load encodings
    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LB  = 3'b001;
    localparam logic [2:0] OP_LBU = 3'b010;
    localparam logic [2:0] OP_LH  = 3'b011;
    localparam logic [2:0] OP_LHU = 3'b100;

    // Store encodings
    localparam logic [2:0] OP_SW  = 3'b000;
    localparam logic [2:0] OP_SB  = 3'b001;
    localparam logic [2:0] OP_SH  = 3'b011;

    // Exception codes
    localparam logic [1:0] EXC_NONE = 2'b00;
    localparam logic [1:0] EXC_ADEL = 2'b01;
    localparam logic [1:0] EXC_ADES = 2'b10;
    localparam logic [1:0] EXC_BUS  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10
    } size_e;

    // Unlisted encodings fall back to a full word access.
    function automatic size_e op_size(input logic we, input logic [2:0] op);
        size_e sz;
        sz = SZ_WORD;
        if (we) begin
            case (op)
                OP_SB:   sz = SZ_BYTE;
                OP_SH:   sz = SZ_HALF;
                default: sz = SZ_WORD;
            endcase
        end else begin
            case (op)
                OP_LB, OP_LBU: sz = SZ_BYTE;
                OP_LH, OP_LHU: sz = SZ_HALF;
                default:       sz = SZ_WORD;
            endcase
        end
        return sz;
    endfunction

endpackage

// File: rtl/dm_access_ctrl_load_extend.sv
// load_extend: selects the addressed byte/halfword of a memory word and
// sign- or zero-extends it according to the load opcode.
//   word   - 32-bit word read from memory
//   lane   - byte address bits [1:0] of the load
//   op     - load opcode (lb/lh sign-extend, lbu/lhu zero-extend, else word)
//   result - extended 32-bit load value
module load_extend
    import dm_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  op,
    output logic [31:0] result
);

    logic signed [7:0]  byte_sel;
    logic signed [15:0] half_sel;

    always_comb begin
        case (lane)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = lane[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        case (op)
            OP_LB:   result = 32'(byte_sel);
            OP_LBU:  result = {24'd0, byte_sel};
            OP_LH:   result = 32'(half_sel);
            OP_LHU:  result = {16'd0, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: MEM-stage data-memory access controller.
// Accepts one load/store from the pipeline, checks alignment, drives a
// request/acknowledge memory port with byte enables and lane-replicated
// store data, extends load data, and reports a one-cycle completion with
// an exception code (misaligned load/store or bus timeout).
//   clk, reset                       - clock, async active-low reset
//   cpu_req/we/op/addr/wdata         - access from the pipeline
//   stall                            - freeze pipeline while access pending
//   ld_data, exc_code, done          - completion results
//   dm_req/we/be/addr/wdata          - memory request port
//   dm_ack, dm_rdata                 - memory response
module dm_access_ctrl
    import dm_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [2:0]  cpu_op,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        stall,
    output logic [31:0] ld_data,
    output logic [1:0]  exc_code,
    output logic        done,
    output logic        dm_req,
    output logic        dm_we,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e      state, state_nx;
    logic [7:0]  cnt;
    logic [2:0]  op_q;
    logic [1:0]  lane_q;
    size_e       sz;
    logic        aligned;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [31:0] ext_data;
    logic        timeout_hit;

    always_comb begin
        sz      = op_size(cpu_we, cpu_op);
        aligned = 1'b1;
        be_c    = 4'b1111;
        wdata_c = cpu_wdata;
        case (sz)
            SZ_HALF: begin
                aligned = ~cpu_addr[0];
                be_c    = cpu_addr[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{cpu_wdata[15:0]}};
            end
            SZ_BYTE: begin
                be_c    = 4'b0001 << cpu_addr[1:0];
                wdata_c = {4{cpu_wdata[7:0]}};
            end
            default: begin
                aligned = (cpu_addr[1:0] == 2'b00);
            end
        endcase
    end

    load_extend u_load_extend (
        .word   (dm_rdata),
        .lane   (lane_q),
        .op     (op_q),
        .result (ext_data)
    );

    // An ack in the last allowed cycle wins over the timeout (ack is tested first).
    assign timeout_hit = (cnt == CNT_LAST);

    assign stall = ((state == ST_IDLE) && cpu_req) || (state == ST_ACCESS);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (cpu_req) state_nx = aligned ? ST_ACCESS : ST_DONE;
            end
            ST_ACCESS: begin
                if (dm_ack || timeout_hit) state_nx = ST_DONE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= 8'd0;
            op_q     <= 3'd0;
            lane_q   <= 2'd0;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_be    <= 4'b0000;
            dm_addr  <= 32'd0;
            dm_wdata <= 32'd0;
            ld_data  <= 32'd0;
            exc_code <= EXC_NONE;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        if (aligned) begin
                            dm_req   <= 1'b1;
                            dm_we    <= cpu_we;
                            dm_addr  <= {cpu_addr[31:2], 2'b00};
                            dm_be    <= be_c;
                            dm_wdata <= wdata_c;
                            op_q     <= cpu_op;
                            lane_q   <= cpu_addr[1:0];
                            cnt      <= 8'd0;
                        end else begin
                            exc_code <= cpu_we ? EXC_ADES : EXC_ADEL;
                            done     <= 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (dm_ack) begin
                        dm_req   <= 1'b0;
                        done     <= 1'b1;
                        exc_code <= EXC_NONE;
                        if (!dm_we) ld_data <= ext_data;
                    end else if (timeout_hit) begin
                        dm_req   <= 1'b0;
                        done     <= 1'b1;
                        exc_code <= EXC_BUS;
                        ld_data  <= 32'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
